ysyx_24100027_ifu: RTL and testbench

YSYX_24100027_IFU -- requirements
Module: ysyx_24100027_ifu

---
 rtl/ysyx_24100027_ifu_pkg.sv | 28 ++
 rtl/ysyx_24100027_ifu_if.sv | 48 ++++
 rtl/ysyx_24100027_npc_adder.sv | 33 +++
 rtl/ysyx_24100027_ifu.sv | 108 ++++++++++
 tb/tb_ysyx_24100027_ifu.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24100027_ifu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100027_ifu_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                FSM state encoding, reset PC default, sequential increment.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_24100027_ifu_pkg;

   // Fetch FSM states; 3 bits covers the six states with room to spare.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_EXEC = 3'd4,
      ST_ERR  = 3'd5
   } ifu_state_e;

   // Default first fetch address after reset.
   localparam logic [31:0] c_reset_pc = 32'h8000_0000;

   // Sequential instruction increment (one 32-bit instruction).
   localparam logic [31:0] c_pc_incr  = 32'd4;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100027_ifu_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100027_ifu_if
//  Description : Bundle of the IFU's memory, decoder and branch-control
//                signals. master = IFU side, slave = surrounding system.
//  Revision    : 1.0  initial release
// ============================================================================
interface ysyx_24100027_ifu_if;

   // Branch control from the execute stage
   logic        pc_a_sel;
   logic        pc_b_sel;
   logic [31:0] imm;
   logic [31:0] rs1;
   logic        commit;

   // Instruction memory request/response
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;

   // Decoder handoff and status
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] pc;
   logic        fault;

   modport master (
      input  pc_a_sel, pc_b_sel, imm, rs1, commit,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      input  inst_ready,
      output imem_req_valid, imem_addr, inst, inst_valid, pc, fault
   );

   modport slave (
      output pc_a_sel, pc_b_sel, imm, rs1, commit,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      output inst_ready,
      input  imem_req_valid, imem_addr, inst, inst_valid, pc, fault
   );

endinterface
`default_nettype wire

// File: rtl/ysyx_24100027_npc_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100027_npc_adder
//  Description : Next-PC computation. Operand A is +4 or the immediate,
//                operand B is the current pc or rs1 (jalr). The 32-bit sum
//                wraps and bit 0 is forced low.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_24100027_npc_adder
   import ysyx_24100027_ifu_pkg::*;
(
   input  logic        pc_a_sel_i,
   input  logic        pc_b_sel_i,
   input  logic [31:0] imm_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] pc_i,
   output logic [31:0] next_pc_o
);

   logic [31:0] w_op_a;
   logic [31:0] w_op_b;
   logic [31:0] w_sum;

   assign w_op_a = pc_a_sel_i ? imm_i : c_pc_incr;
   assign w_op_b = pc_b_sel_i ? rs1_i : pc_i;

   // Carry out of bit 31 is intentionally dropped: addresses wrap.
   assign w_sum     = w_op_a + w_op_b;
   assign next_pc_o = {w_sum[31:1], 1'b0};

endmodule
`default_nettype wire

// File: rtl/ysyx_24100027_ifu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100027_ifu
//  Description : Instruction fetch unit. Issues one fetch at a time, holds
//                the returned instruction for the decoder, waits for the
//                instruction to retire, then loads the next pc. Bus errors
//                and misaligned targets park the unit in a sticky fault
//                state that only reset clears.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_24100027_ifu
   import ysyx_24100027_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_reset_pc
)(
   input  logic                       clk,
   input  logic                       rst_n,
   ysyx_24100027_ifu_if.master        bus
);

   ifu_state_e  state_q;
   ifu_state_e  state_d;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] inst_q;
   logic [31:0] inst_d;
   logic [31:0] w_next_pc;

   ysyx_24100027_npc_adder u_npc_adder (
      .pc_a_sel_i (bus.pc_a_sel),
      .pc_b_sel_i (bus.pc_b_sel),
      .imm_i      (bus.imm),
      .rs1_i      (bus.rs1),
      .pc_i       (pc_q),
      .next_pc_o  (w_next_pc)
   );

   // State, pc and instruction registers; reset drops any in-flight fetch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   // Next state: each state reacts only to its own handshake, so stray
   // responses or commits in other states fall through to the hold defaults.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (bus.imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.imem_rsp_valid) begin
               if (bus.imem_rsp_err) begin
                  state_d = ST_ERR;
               end else begin
                  inst_d  = bus.imem_rsp_data;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (bus.inst_ready) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (bus.commit) begin
               // pc takes the target even when misaligned so software can
               // see where the bad jump went.
               pc_d    = w_next_pc;
               state_d = w_next_pc[1] ? ST_ERR : ST_REQ;
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_ERR;
         end
      endcase
   end

   // Outputs decode only registered state, never live inputs.
   assign bus.imem_req_valid = (state_q == ST_REQ);
   assign bus.imem_addr      = pc_q;
   assign bus.inst           = inst_q;
   assign bus.inst_valid     = (state_q == ST_HOLD);
   assign bus.pc             = pc_q;
   assign bus.fault          = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100027_ifu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24100027_ifu
//  Description : Self-checking bench for the IFU. A transaction-level model
//                tracks where the current fetch is (waiting to issue, in
//                flight, held for decode, executing) and the architectural
//                pc/inst/fault; every cycle the DUT outputs are compared to
//                it. Directed scenarios come first, then random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_24100027_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ysyx_24100027_ifu_if bus();

   ysyx_24100027_ifu #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   bit          m_fault;
   bit          m_startup;   // one dead cycle after reset
   bit          m_issue;     // fetch waiting to be accepted by memory
   bit          m_flight;    // fetch accepted, awaiting response
   bit          m_decode;    // instruction offered to decoder
   bit          m_execute;   // instruction in execute, awaiting commit

   function automatic logic [31:0] ref_npc(input bit a, input bit b,
                                           input logic [31:0] imm,
                                           input logic [31:0] rs1,
                                           input logic [31:0] pc);
      logic [31:0] s;
      s = (a ? imm : 32'd4) + (b ? rs1 : pc);
      return s & 32'hFFFF_FFFE;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   // Model advances on the same edge the DUT samples its inputs.
   always @(posedge clk) begin
      if (!rst_n) begin
         chk_en    <= 1'b1;
         m_pc      <= RST_PC;
         m_inst    <= 32'd0;
         m_fault   <= 1'b0;
         m_startup <= 1'b1;
         m_issue   <= 1'b0;
         m_flight  <= 1'b0;
         m_decode  <= 1'b0;
         m_execute <= 1'b0;
      end else if (m_fault) begin
         m_fault <= 1'b1;
      end else if (m_startup) begin
         m_startup <= 1'b0;
         m_issue   <= 1'b1;
      end else if (m_issue) begin
         if (bus.imem_req_ready) begin
            m_issue  <= 1'b0;
            m_flight <= 1'b1;
         end
      end else if (m_flight) begin
         if (bus.imem_rsp_valid) begin
            m_flight <= 1'b0;
            if (bus.imem_rsp_err) m_fault <= 1'b1;
            else begin
               m_inst   <= bus.imem_rsp_data;
               m_decode <= 1'b1;
            end
         end
      end else if (m_decode) begin
         if (bus.inst_ready) begin
            m_decode  <= 1'b0;
            m_execute <= 1'b1;
         end
      end else if (m_execute) begin
         if (bus.commit) begin
            m_execute <= 1'b0;
            m_pc <= ref_npc(bus.pc_a_sel, bus.pc_b_sel, bus.imm, bus.rs1, m_pc);
            if ((ref_npc(bus.pc_a_sel, bus.pc_b_sel, bus.imm, bus.rs1, m_pc) & 32'h2) != 0)
               m_fault <= 1'b1;
            else
               m_issue <= 1'b1;
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk1("fault", bus.fault, m_fault);
         chk("pc", bus.pc, m_pc);
         chk("inst", bus.inst, m_inst);
         chk1("req_valid", bus.imem_req_valid, m_issue && !m_fault);
         chk1("inst_valid", bus.inst_valid, m_decode && !m_fault);
         if (m_issue && !m_fault) chk("imem_addr", bus.imem_addr, m_pc);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
      chk1("req_wait", bus.imem_req_valid, 1'b1);
   endtask

   task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                           input bit err, input int rdy_wait, input int rsp_wait,
                           input int dec_wait, input bit spur);
      wait_req();
      chk("fetch_addr", bus.imem_addr, exp_addr);
      bus.imem_req_ready = 1'b0;
      repeat (rdy_wait) begin
         tick();
         chk1("bp_req_valid", bus.imem_req_valid, 1'b1);
         chk("bp_addr", bus.imem_addr, exp_addr);
      end
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      repeat (rsp_wait) tick();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      bus.imem_rsp_err   = err;
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_err   = 1'b0;
      bus.imem_rsp_data  = $urandom;
      if (err) return;
      chk("inst_latch", bus.inst, data);
      repeat (dec_wait) begin
         bus.commit = spur;
         tick();
         bus.commit = 1'b0;
         chk("hold_inst", bus.inst, data);
         chk1("hold_valid", bus.inst_valid, 1'b1);
         chk("hold_pc", bus.pc, exp_addr);
      end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
   endtask

   task automatic do_commit(input bit a, input bit b, input logic [31:0] imm,
                            input logic [31:0] rs1);
      bus.pc_a_sel = a;
      bus.pc_b_sel = b;
      bus.imm      = imm;
      bus.rs1      = rs1;
      bus.commit   = 1'b1;
      tick();
      bus.commit   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.pc_a_sel       = 1'b0;
      bus.pc_b_sel       = 1'b0;
      bus.imm            = 32'd0;
      bus.rs1            = 32'd0;
      bus.commit         = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.imem_rsp_err   = 1'b0;
      bus.inst_ready     = 1'b0;

      // Reset state
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_pc", bus.pc, 32'h8000_0000);
      chk("rst_inst", bus.inst, 32'd0);
      chk1("rst_fault", bus.fault, 1'b0);
      chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
      chk1("rst_inst_valid", bus.inst_valid, 1'b0);
      rst_n = 1'b1;

      // Sequential fetch
      do_fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 0, 2, 1, 1'b0);
      do_commit(1'b0, 1'b0, 32'h0, 32'h0);
      chk1("commit_to_req", bus.imem_req_valid, 1'b1);
      do_fetch(32'h8000_0004, 32'h0000_0013, 1'b0, 0, 1, 0, 1'b0);

      // Forward jump to 0x80000010, with memory and decoder backpressure and
      // a spurious commit while the instruction is held
      do_commit(1'b1, 1'b0, 32'h0000_000C, 32'h0);
      do_fetch(32'h8000_0010, 32'h0040_0093, 1'b0, 5, 0, 3, 1'b1);

      // Spurious response while executing
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rsp_valid = 1'b0;
      chk("exec_rsp_ignored", bus.inst, 32'h0040_0093);

      // Backward branch and jalr with odd target
      do_commit(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
      do_fetch(32'h8000_0000, 32'h0000_0067, 1'b0, 0, 0, 0, 1'b0);
      do_commit(1'b1, 1'b1, 32'h0000_0004, 32'h8000_1001);
      do_fetch(32'h8000_1004, 32'h0000_0013, 1'b0, 0, 0, 0, 1'b0);

      // Misaligned jalr target -> fault with pc loaded
      do_commit(1'b1, 1'b1, 32'h0, 32'h8000_0002);
      chk("misalign_pc", bus.pc, 32'h8000_0002);
      chk1("misalign_fault", bus.fault, 1'b1);
      bus.imem_req_ready = 1'b1;
      repeat (3) begin
         tick();
         chk1("err_no_req", bus.imem_req_valid, 1'b0);
      end
      bus.imem_req_ready = 1'b0;

      // Bus error -> sticky fault until reset
      do_reset();
      do_fetch(32'h8000_0000, 32'h0, 1'b1, 0, 1, 0, 1'b0);
      chk1("buserr_fault", bus.fault, 1'b1);
      bus.imem_req_ready = 1'b1;
      repeat (4) begin
         tick();
         chk1("buserr_sticky", bus.fault, 1'b1);
      end
      bus.imem_req_ready = 1'b0;

      // Reset while a fetch is in flight; late response must be dropped
      do_reset();
      wait_req();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      do_reset();
      tick();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD0_BAD0;
      tick();
      bus.imem_rsp_valid = 1'b0;
      do_fetch(32'h8000_0000, 32'h0010_0073, 1'b0, 0, 0, 0, 1'b0);
      chk("late_rsp_dropped", bus.inst, 32'h0010_0073);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst_n = !(($urandom % 300) == 0) && !(bus.fault && (($urandom % 8) == 0));
         bus.imem_req_ready = ($urandom % 3) != 0;
         bus.imem_rsp_valid = ($urandom % 3) == 0;
         bus.imem_rsp_err   = ($urandom % 25) == 0;
         bus.imem_rsp_data  = $urandom;
         bus.inst_ready     = ($urandom % 2) == 0;
         bus.commit         = ($urandom % 3) == 0;
         bus.pc_a_sel       = ($urandom % 2) == 0;
         bus.pc_b_sel       = ($urandom % 2) == 0;
         bus.imm            = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         bus.rs1            = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         tick();
      end

      rst_n = 1'b1;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
